// File: rtl/reshape_stream_router.sv
// reshape_stream_router: routes one input stream to a single selected reshape
// operator, merges that operator's output through a small registered FIFO and
// sequences one layer (start, drain, done, clear) from latched beat totals.
module reshape_stream_router #(
    parameter int DATA_W      = 128,
    parameter int N_OPS       = 4,
    parameter int CNT_W       = 24,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_OPS-1:0]          Control_Reshape,
    input  logic [CNT_W-1:0]          In_Total,
    input  logic [CNT_W-1:0]          Out_Total,
    input  logic                      Abort,
    output logic [1:0]                State,
    output logic [N_OPS-1:0]          Op_Start,
    output logic                      Op_Clear,
    output logic                      Done,
    output logic                      Cfg_Err,
    input  logic [DATA_W-1:0]         S_Data,
    input  logic                      S_Valid,
    output logic                      S_Ready,
    output logic [DATA_W-1:0]         Op_S_Data,
    output logic [N_OPS-1:0]          Op_S_Valid,
    input  logic [N_OPS-1:0]          Op_S_Ready,
    input  logic [N_OPS*DATA_W-1:0]   Op_M_Data,
    input  logic [N_OPS-1:0]          Op_M_Valid,
    output logic [N_OPS-1:0]          Op_M_Ready,
    output logic [DATA_W-1:0]         M_Data,
    output logic                      M_Valid,
    input  logic                      M_Ready,
    output logic                      M_Last
);

    localparam int SEL_W = $clog2(N_OPS);
    localparam int PTR_W = $clog2(OFIFO_DEPTH);
    localparam int FCW   = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [SEL_W-1:0]    sel;
    logic [CNT_W-1:0]    in_total;
    logic [CNT_W-1:0]    out_total;
    logic [CNT_W-1:0]    in_cnt;
    logic [CNT_W-1:0]    acc_cnt;
    logic [CNT_W-1:0]    out_cnt;
    logic [N_OPS-1:0]    op_start_q;
    logic                op_clear_q;
    logic                done_q;
    logic                cfg_err_q;

    logic [DATA_W-1:0]   fifo_mem [OFIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [FCW-1:0]      fifo_cnt;

    logic [SEL_W-1:0]    cfg_index;
    logic                cfg_onehot;
    logic                cfg_totals_ok;
    logic [DATA_W-1:0]   op_data [N_OPS];
    logic                active;
    logic                fifo_full;
    logic                fifo_empty;
    logic                s_ready;
    logic                op_ready;
    logic                s_fire;
    logic                op_fire;
    logic                m_fire;
    logic                last_in;
    logic                last_out;
    logic                flush;

    // Operator index of the highest set select bit (only used when one-hot).
    always_comb begin
        cfg_index = '0;
        for (int unsigned k = 0; k < N_OPS; k++) begin
            if (Control_Reshape[k]) cfg_index = SEL_W'(k);
        end
    end

    assign cfg_onehot    = $onehot(Control_Reshape);
    assign cfg_totals_ok = (In_Total != '0) && (Out_Total != '0);

    // Unpack the flat operator output bus into one word per operator.
    always_comb begin
        for (int unsigned k = 0; k < N_OPS; k++) begin
            op_data[k] = Op_M_Data[k*DATA_W +: DATA_W];
        end
    end

    assign active     = (state == ST_RUN) || (state == ST_DRAIN);
    assign fifo_full  = (fifo_cnt == FCW'(OFIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign s_ready    = (state == ST_RUN) && Op_S_Ready[sel] && (in_cnt < in_total);
    assign op_ready   = active && !fifo_full && (acc_cnt < out_total);
    assign s_fire     = S_Valid && s_ready;
    assign op_fire    = op_ready && Op_M_Valid[sel];
    assign m_fire     = !fifo_empty && M_Ready;
    assign last_in    = (in_cnt == in_total - CNT_W'(1));
    assign last_out   = (out_cnt == out_total - CNT_W'(1));
    // Leaving a layer (abort or DONE) empties the FIFO and zeroes all counters.
    assign flush      = (active && Abort) || (state == ST_DONE);

    // Fan the handshakes out to the selected operator only.
    always_comb begin
        Op_S_Valid = '0;
        Op_M_Ready = '0;
        for (int unsigned k = 0; k < N_OPS; k++) begin
            if (sel == SEL_W'(k)) begin
                Op_S_Valid[k] = s_fire;
                Op_M_Ready[k] = op_ready;
            end
        end
    end

    assign Op_S_Data = S_Data;
    assign S_Ready   = s_ready;
    assign M_Valid   = !fifo_empty;
    assign M_Data    = fifo_mem[rd_ptr];
    assign M_Last    = M_Valid && last_out;
    assign State     = state;
    assign Op_Start  = op_start_q;
    assign Op_Clear  = op_clear_q;
    assign Done      = done_q;
    assign Cfg_Err   = cfg_err_q;

    // FIFO storage: capture the selected operator's beat on its handshake.
    always_ff @(posedge clk) begin
        if (op_fire) fifo_mem[wr_ptr] <= op_data[sel];
    end

    // Layer sequencer, beat counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= '0;
            in_total   <= '0;
            out_total  <= '0;
            in_cnt     <= '0;
            acc_cnt    <= '0;
            out_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            op_start_q <= '0;
            op_clear_q <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            op_start_q <= '0;
            op_clear_q <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;

            if (flush) begin
                in_cnt   <= '0;
                acc_cnt  <= '0;
                out_cnt  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (s_fire) in_cnt <= in_cnt + CNT_W'(1);
                if (op_fire) begin
                    acc_cnt <= acc_cnt + CNT_W'(1);
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (m_fire) begin
                    out_cnt <= out_cnt + CNT_W'(1);
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                end
                case ({op_fire, m_fire})
                    2'b10:   fifo_cnt <= fifo_cnt + FCW'(1);
                    2'b01:   fifo_cnt <= fifo_cnt - FCW'(1);
                    default: ;
                endcase
            end

            case (state)
                ST_IDLE: begin
                    if (Control_Reshape != '0) begin
                        if (cfg_onehot && cfg_totals_ok) begin
                            if (!Abort) begin
                                sel        <= cfg_index;
                                in_total   <= In_Total;
                                out_total  <= Out_Total;
                                op_start_q <= N_OPS'(1) << cfg_index;
                                state      <= ST_RUN;
                            end
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (Abort) begin
                        op_clear_q <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (m_fire && last_out) begin
                        done_q     <= 1'b1;
                        op_clear_q <= 1'b1;
                        state      <= ST_DONE;
                    end else if (state == ST_RUN && s_fire && last_in) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reshape_stream_router.sv
// Testbench for reshape_stream_router: table-driven configuration vectors plus
// layer sequences checked through an expected-output scoreboard queue.
module tb_reshape_stream_router;

    localparam int DATA_W      = 128;
    localparam int N_OPS       = 4;
    localparam int CNT_W       = 24;
    localparam int OFIFO_DEPTH = 4;
    localparam logic [DATA_W-1:0] ROGUE = {4{32'hDEADBEEF}};

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_OPS-1:0]        Control_Reshape;
    logic [CNT_W-1:0]        In_Total;
    logic [CNT_W-1:0]        Out_Total;
    logic                    Abort;
    logic [1:0]              State;
    logic [N_OPS-1:0]        Op_Start;
    logic                    Op_Clear;
    logic                    Done;
    logic                    Cfg_Err;
    logic [DATA_W-1:0]       S_Data;
    logic                    S_Valid;
    logic                    S_Ready;
    logic [DATA_W-1:0]       Op_S_Data;
    logic [N_OPS-1:0]        Op_S_Valid;
    logic [N_OPS-1:0]        Op_S_Ready;
    logic [N_OPS*DATA_W-1:0] Op_M_Data;
    logic [N_OPS-1:0]        Op_M_Valid;
    logic [N_OPS-1:0]        Op_M_Ready;
    logic [DATA_W-1:0]       M_Data;
    logic                    M_Valid;
    logic                    M_Ready;
    logic                    M_Last;

    always #5 clk = ~clk;

    reshape_stream_router #(
        .DATA_W(DATA_W),
        .N_OPS(N_OPS),
        .CNT_W(CNT_W),
        .OFIFO_DEPTH(OFIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Control_Reshape(Control_Reshape),
        .In_Total(In_Total),
        .Out_Total(Out_Total),
        .Abort(Abort),
        .State(State),
        .Op_Start(Op_Start),
        .Op_Clear(Op_Clear),
        .Done(Done),
        .Cfg_Err(Cfg_Err),
        .S_Data(S_Data),
        .S_Valid(S_Valid),
        .S_Ready(S_Ready),
        .Op_S_Data(Op_S_Data),
        .Op_S_Valid(Op_S_Valid),
        .Op_S_Ready(Op_S_Ready),
        .Op_M_Data(Op_M_Data),
        .Op_M_Valid(Op_M_Valid),
        .Op_M_Ready(Op_M_Ready),
        .M_Data(M_Data),
        .M_Valid(M_Valid),
        .M_Ready(M_Ready),
        .M_Last(M_Last)
    );

    typedef struct {
        logic [N_OPS-1:0] ctrl;
        int               in_t;
        int               out_t;
        bit               err;
    } cfg_vec_t;

    cfg_vec_t cv [5];

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] s_q[$];
    logic [DATA_W-1:0] op_q[$];
    logic [DATA_W-1:0] exp_q[$];

    int op_sel, ups, out_n, exp_pushed, out_seen, in_acc, occ, cyc;
    int rogue, bp_mode;
    bit s_en, rogue_en;
    int done_cnt, clr_cnt, cfg_cnt, done_cyc, last_fire_cyc;
    int full_seen, drain_block_seen, rogue_hit;
    bit [3:0] mr_pat = 4'b1001;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock: drive inputs from the models, observe, update models.
    task automatic step();
        logic [DATA_W-1:0] d;
        S_Valid = s_en && (s_q.size() > 0);
        S_Data  = S_Valid ? s_q[0] : '0;
        Op_M_Valid = '0;
        Op_M_Data  = '0;
        if (op_q.size() > 0) begin
            Op_M_Valid[op_sel] = 1'b1;
            Op_M_Data[op_sel*DATA_W +: DATA_W] = op_q[0];
        end
        if (rogue_en) begin
            Op_M_Valid[rogue] = 1'b1;
            Op_M_Data[rogue*DATA_W +: DATA_W] = ROGUE;
        end
        M_Ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? mr_pat[cyc % 4] : 1'b0;
        #1;
        done_cnt += int'(Done);
        clr_cnt  += int'(Op_Clear);
        cfg_cnt  += int'(Cfg_Err);
        if (Done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (rogue_en) chk("rogue_ready", Op_M_Ready[rogue], 1'b0);
        if (occ >= OFIFO_DEPTH) begin
            full_seen++;
            chk("full_ready", Op_M_Ready[op_sel], 1'b0);
        end
        if (State == 2'd2 && S_Valid && !S_Ready) drain_block_seen++;
        if (M_Valid === 1'b1 && M_Data === ROGUE) rogue_hit++;
        if (S_Valid && S_Ready === 1'b1) begin
            d = s_q.pop_front();
            in_acc++;
            for (int j = 0; j < ups; j++) begin
                op_q.push_back(d + DATA_W'(j));
                if (exp_pushed < out_n) begin
                    exp_q.push_back(d + DATA_W'(j));
                    exp_pushed++;
                end
            end
        end
        if (Op_M_Valid[op_sel] && Op_M_Ready[op_sel] === 1'b1) begin
            void'(op_q.pop_front());
            occ++;
        end
        if (M_Valid === 1'b1 && M_Ready) begin
            occ--;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL extra_beat: actual=%0h required=no beat", M_Data);
            end else begin
                chk("m_data", M_Data, exp_q.pop_front());
                chk("m_last", M_Last, out_seen == out_n - 1);
            end
            out_seen++;
            if (out_seen == out_n) last_fire_cyc = cyc;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic start_layer(input int sel, input int in_n, input int on,
                               input int up, input int bp, input bit rg, input int rg_op);
        s_q.delete();
        op_q.delete();
        exp_q.delete();
        for (int i = 0; i < in_n + 2; i++) s_q.push_back({$urandom, $urandom, $urandom, $urandom});
        op_sel = sel; ups = up; out_n = on; exp_pushed = 0; out_seen = 0;
        in_acc = 0; occ = 0; bp_mode = bp; rogue_en = rg; rogue = rg_op; s_en = 1'b1;
        done_cnt = 0; clr_cnt = 0; cfg_cnt = 0; done_cyc = -1; last_fire_cyc = -2;
        full_seen = 0; drain_block_seen = 0; rogue_hit = 0;
        Control_Reshape = N_OPS'(1) << sel;
        In_Total  = CNT_W'(in_n);
        Out_Total = CNT_W'(on);
        step();
        Control_Reshape = '0;
        chk("start_state", State, 2'd1);
        chk("op_start", Op_Start, N_OPS'(1) << sel);
    endtask

    task automatic run_layer(input int sel, input int in_n, input int on,
                             input int up, input int bp, input bit rg, input int rg_op);
        int guard;
        start_layer(sel, in_n, on, up, bp, rg, rg_op);
        step();
        chk("op_start_pulse", Op_Start, '0);
        guard = 0;
        while (done_cnt == 0 && guard < 400) begin
            step();
            guard++;
        end
        if (done_cnt == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL layer_timeout: actual=no Done after %0d cycles required=Done", guard);
        end
        chk("done_once", done_cnt, 1);
        chk("done_latency", done_cyc, last_fire_cyc + 1);
        chk("clear_with_done", clr_cnt, 1);
        chk("end_state", State, 2'd0);
        chk("done_low", Done, 1'b0);
        chk("beats_out", out_seen, on);
        chk("exp_empty", exp_q.size(), 0);
        chk("mvalid_idle", M_Valid, 1'b0);
        s_en = 1'b0;
        bp_mode = 0;
        rogue_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cv[0] = '{4'b0110, 8, 8, 1'b1};
        cv[1] = '{4'b0001, 0, 5, 1'b1};
        cv[2] = '{4'b0010, 5, 0, 1'b1};
        cv[3] = '{4'b1100, 3, 3, 1'b1};
        cv[4] = '{4'b0000, 8, 8, 1'b0};

        rst = 1'b1; Abort = 1'b0; Op_S_Ready = '1;
        Control_Reshape = 4'b0001; In_Total = 4; Out_Total = 4;
        S_Valid = 1'b0; S_Data = '0; Op_M_Valid = '0; Op_M_Data = '0; M_Ready = 1'b0;
        s_en = 1'b0; rogue_en = 1'b0; bp_mode = 0; op_sel = 0; ups = 1; out_n = 0;
        exp_pushed = 0; out_seen = 0; in_acc = 0; occ = 0; cyc = 0; rogue = 0;
        done_cnt = 0; clr_cnt = 0; cfg_cnt = 0; done_cyc = -1; last_fire_cyc = -2;
        full_seen = 0; drain_block_seen = 0; rogue_hit = 0;
        repeat (3) step();

        chk("rst_state", State, 2'd0);
        chk("rst_op_start", Op_Start, '0);
        chk("rst_pulses", {Op_Clear, Done, Cfg_Err}, 3'b000);
        chk("rst_s_ready", S_Ready, 1'b0);
        chk("rst_op_s_valid", Op_S_Valid, '0);
        chk("rst_op_m_ready", Op_M_Ready, '0);
        chk("rst_m_valid", M_Valid, 1'b0);
        chk("rst_m_last", M_Last, 1'b0);

        Control_Reshape = '0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            Control_Reshape = cv[i].ctrl;
            In_Total  = CNT_W'(cv[i].in_t);
            Out_Total = CNT_W'(cv[i].out_t);
            step();
            Control_Reshape = '0;
            chk("cfg_err", Cfg_Err, cv[i].err);
            chk("cfg_no_start", Op_Start, '0);
            chk("cfg_state", State, 2'd0);
            step();
            chk("cfg_err_pulse", Cfg_Err, 1'b0);
        end

        // Route with an idle operator shouting on its output.
        run_layer(1, 8, 8, 1, 0, 1'b1, 0);
        chk("rogue_on_m_data", rogue_hit, 0);

        // Upsample: 4 in, 16 out; the extra queued inputs must be held off.
        run_layer(2, 4, 16, 4, 0, 1'b0, 0);
        chk("ups_in_accepted", in_acc, 4);
        chk("ups_drain_blocks", drain_block_seen > 0, 1'b1);

        // Output backpressure 1-0-0-1 fills the FIFO.
        run_layer(3, 8, 8, 1, 1, 1'b0, 0);
        chk("bp_fifo_filled", full_seen > 0, 1'b1);

        // Output total reached while still in RUN.
        run_layer(0, 6, 3, 1, 0, 1'b0, 0);
        chk("early_in_unconsumed", in_acc < 6, 1'b1);

        // Abort after 3 input beats with 2 entries in the FIFO.
        start_layer(2, 8, 8, 1, 2, 1'b0, 0);
        for (int g = 0; g < 20 && in_acc < 3; g++) step();
        chk("abort_setup_in", in_acc, 3);
        chk("abort_setup_occ", occ, 2);
        s_en = 1'b0;
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk("abort_state", State, 2'd0);
        chk("abort_m_valid", M_Valid, 1'b0);
        chk("abort_clear", Op_Clear, 1'b1);
        chk("abort_no_done", Done, 1'b0);
        step();
        chk("abort_clear_pulse", Op_Clear, 1'b0);
        chk("abort_done_count", done_cnt, 0);
        bp_mode = 0;

        run_layer(2, 5, 5, 1, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_layer_quiet", M_Valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
